// File: rtl/uart_rx_buffer.sv
// Receive-side buffer: drains bytes from the CPLD UART into a first-word fall-through FIFO.
// Build option: define UART_RX_DROP_ON_FULL_EN to read and discard bytes when full (default: back-pressure).
module uart_rx_buffer #(
    parameter int DEPTH_LOG2    = 4,
    parameter int RD_LOW_CYCLES = 2,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_ready,
    input  logic [7:0]            ram1_data_in,
    output logic                  rdn,
    output logic                  bus_req,
    input  logic                  bus_gnt,
    input  logic                  pop,
    output logic [7:0]            rd_data,
    output logic                  rx_avail,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    typedef enum logic [2:0] {IDLE, REQ, STROBE, CAPTURE, WAIT_LO} state_t;

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LAST = 4'(RD_LOW_CYCLES - 1);

    state_t                state;
    state_t                state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                  dr_s;
    logic [3:0]            cnt;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2:0]   wptr;
    logic [DEPTH_LOG2:0]   rptr;
    logic                  empty;
    logic                  full;
    logic                  pop_ok;
    logic                  push;
    logic                  drop;
    logic                  lost;
    logic                  can_start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync <= '0;
        else      sync <= {sync[SYNC_STAGES-2:0], data_ready};
    end

    assign dr_s = sync[SYNC_STAGES-1];

    assign empty  = (wptr == rptr);
    assign full   = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                    (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
    assign pop_ok = pop && !empty;
    // A same-cycle pop frees the slot, so a capture into a full FIFO still lands.
    assign push   = (state == CAPTURE) && (!full || pop_ok);
    assign drop   = (state == CAPTURE) && full && !pop_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)   wptr <= wptr + 1'b1;
            if (pop_ok) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[DEPTH_LOG2-1:0]] <= ram1_data_in;
    end

    assign count    = wptr - rptr;
    assign rx_avail = !empty;
    assign rd_data  = empty ? 8'h00 : mem[rptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == STROBE) cnt <= cnt + 4'd1;
            else                 cnt <= '0;
        end
    end

    always_comb begin
        state_next = state;
        rdn        = 1'b1;
        bus_req    = 1'b0;
        case (state)
            IDLE:    if (dr_s && can_start) state_next = REQ;
            REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) state_next = STROBE;
            end
            STROBE: begin
                bus_req = 1'b1;
                rdn     = 1'b0;
                if (cnt == CNT_LAST) state_next = CAPTURE;
            end
            CAPTURE: begin
                bus_req    = 1'b1;
                state_next = WAIT_LO;
            end
            WAIT_LO: if (!dr_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef UART_RX_DROP_ON_FULL_EN
    assign can_start = 1'b1;
    assign lost      = drop;
`else
    logic dr_s_d;
    logic pending;

    // While blocked on a full FIFO, a second dataReady rise means the CPLD overwrote its byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dr_s_d  <= 1'b0;
            pending <= 1'b0;
        end else begin
            dr_s_d <= dr_s;
            if (state != IDLE)     pending <= 1'b0;
            else if (full && dr_s) pending <= 1'b1;
        end
    end

    assign can_start = !full;
    assign lost      = drop || ((state == IDLE) && full && pending && dr_s && !dr_s_d);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              overflow <= 1'b0;
        else if (lost)         overflow <= 1'b1;
        else if (clr_overflow) overflow <= 1'b0;
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: cycle vector table plus scoreboarded byte transfers.
// Honours UART_RX_DROP_ON_FULL_EN to select the matching full-FIFO expectations.
module tb_uart_rx_buffer;

    localparam int RD_LOW = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       data_ready = 1'b0;
    logic [7:0] ram1_data_in = 8'h00;
    logic       bus_gnt = 1'b1;
    logic       pop = 1'b0;
    logic       clr_overflow = 1'b0;
    logic       rdn;
    logic       bus_req;
    logic [7:0] rd_data;
    logic       rx_avail;
    logic [4:0] count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic       dr;
        logic       gnt;
        logic       pp;
        logic [7:0] din;
        logic       e_rdn;
        logic       e_breq;
        logic       care_breq;
        logic       e_avail;
        logic [4:0] e_count;
        logic [7:0] e_rd;
    } vec_t;

    vec_t vecs[11];

    uart_rx_buffer dut (
        .clk(clk), .rst(rst), .data_ready(data_ready), .ram1_data_in(ram1_data_in),
        .rdn(rdn), .bus_req(bus_req), .bus_gnt(bus_gnt), .pop(pop), .rd_data(rd_data),
        .rx_avail(rx_avail), .count(count), .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        data_ready   = v.dr;
        bus_gnt      = v.gnt;
        pop          = v.pp;
        ram1_data_in = v.din;
    endtask

    task automatic popCheck();
        logic [7:0] exp;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL pop: scoreboard empty, rd_data %0h", rd_data);
        end else begin
            exp = sb.pop_front();
            checkOutput("pop data", rd_data, exp);
            checkOutput("pop avail", rx_avail, 1);
        end
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    // One full CPLD handshake; optionally pops the head in the capture cycle.
    task automatic sendByte(input logic [7:0] b, input bit stored, input bit pop_at_cap);
        int guard;
        int n;
        if (stored) sb.push_back(b);
        ram1_data_in = b;
        data_ready   = 1'b1;
        guard = 0;
        while (rdn !== 1'b0 && guard < 60) begin
            tick();
            guard++;
        end
        if (guard >= 60) begin
            checks++;
            errors++;
            $display("[TB] FAIL strobe timeout: rdn %0b expected 0", rdn);
        end
        n = 0;
        while (rdn === 1'b0 && n < 20) begin
            n++;
            tick();
        end
        checkOutput("rdn low cycles", n, RD_LOW);
        if (pop_at_cap) popCheck();
        else            tick();
        data_ready = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int guard;
        int bad;
        bit seen;

        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 8'h00};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 8'h00};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 8'h00};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 8'hA5};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 8'hA5};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 8'hA5};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00};

        #2;
        checkOutput("reset rdn", rdn, 1);
        checkOutput("reset bus_req", bus_req, 0);
        checkOutput("reset count", count, 0);
        checkOutput("reset avail", rx_avail, 0);
        checkOutput("reset rd_data", rd_data, 0);
        checkOutput("reset overflow", overflow, 0);
        #21 rst = 1'b1;
        tick();

        // Single byte, grant already high: cycle-by-cycle vectors.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d rdn", i), rdn, vecs[i].e_rdn);
            if (vecs[i].care_breq) checkOutput($sformatf("vec%0d bus_req", i), bus_req, vecs[i].e_breq);
            checkOutput($sformatf("vec%0d avail", i), rx_avail, vecs[i].e_avail);
            checkOutput($sformatf("vec%0d count", i), count, vecs[i].e_count);
            checkOutput($sformatf("vec%0d rd_data", i), rd_data, vecs[i].e_rd);
        end

        // Burst to full, drain in order, then pop on empty.
        for (int i = 0; i < 16; i++) sendByte(8'(i), 1'b1, 1'b0);
        checkOutput("burst count", count, 16);
        for (int i = 0; i < 16; i++) popCheck();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        checkOutput("empty pop rd_data", rd_data, 0);
        checkOutput("empty pop count", count, 0);
        checkOutput("empty pop avail", rx_avail, 0);

        // Pointer wrap with occupancy cycling 0..5.
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 5; k++) sendByte(8'(8'h80 + r * 5 + k), 1'b1, 1'b0);
            checkOutput("wrap count", count, 5);
            for (int k = 0; k < 5; k++) popCheck();
        end
        checkOutput("wrap drained", count, 0);
        checkOutput("wrap overflow", overflow, 0);

        for (int i = 0; i < 16; i++) sendByte(8'(8'hC0 + i), 1'b1, 1'b0);
`ifdef UART_RX_DROP_ON_FULL_EN
        sendByte(8'hEE, 1'b0, 1'b0);
        checkOutput("drop overflow", overflow, 1);
        checkOutput("drop count", count, 16);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checkOutput("clr overflow", overflow, 0);
        clr_overflow = 1'b1;
        ram1_data_in = 8'hEF;
        data_ready   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (overflow === 1'b1) seen = 1'b1;
        end
        clr_overflow = 1'b0;
        data_ready   = 1'b0;
        checkOutput("set beats clear", seen, 1);
        repeat (4) tick();
        checkOutput("overflow sticky", overflow, 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checkOutput("overflow cleared", overflow, 0);
        sendByte(8'h5A, 1'b1, 1'b1);
        checkOutput("push+pop full count", count, 16);
        checkOutput("push+pop overflow", overflow, 0);
`else
        ram1_data_in = 8'hEE;
        data_ready   = 1'b1;
        bad = 0;
        repeat (15) begin
            tick();
            if (rdn !== 1'b1 || bus_req !== 1'b0) bad++;
        end
        checkOutput("backpressure no strobe", bad, 0);
        checkOutput("backpressure count", count, 16);
        popCheck();
        sendByte(8'hEE, 1'b1, 1'b0);
        checkOutput("late byte count", count, 16);
        checkOutput("late byte overflow", overflow, 0);

        ram1_data_in = 8'h11;
        data_ready   = 1'b1;
        repeat (8) tick();
        data_ready = 1'b0;
        repeat (6) tick();
        clr_overflow = 1'b1;
        ram1_data_in = 8'h22;
        data_ready   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (overflow === 1'b1) seen = 1'b1;
        end
        clr_overflow = 1'b0;
        checkOutput("overwrite set beats clear", seen, 1);
        tick();
        checkOutput("overflow sticky", overflow, 1);
        checkOutput("overwrite count", count, 16);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        checkOutput("overflow cleared", overflow, 0);
        popCheck();
        sendByte(8'h22, 1'b1, 1'b0);
        checkOutput("overwrite kept newest", count, 16);
        popCheck();
        sendByte(8'h5A, 1'b1, 1'b1);
        checkOutput("push+pop count", count, 15);
`endif
        while (sb.size() > 0) popCheck();
        checkOutput("drain count", count, 0);

        // Grant withheld for 10 cycles; strobe must follow the grant by one cycle.
        bus_gnt = 1'b0;
        sb.push_back(8'h6B);
        ram1_data_in = 8'h6B;
        data_ready   = 1'b1;
        guard = 0;
        while (bus_req !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput("request raised", bus_req, 1);
        bad = 0;
        repeat (10) begin
            tick();
            if (bus_req !== 1'b1 || rdn !== 1'b1) bad++;
        end
        checkOutput("no strobe without grant", bad, 0);
        bus_gnt = 1'b1;
        tick();
        checkOutput("strobe after grant", rdn, 0);
        repeat (3) tick();
        data_ready = 1'b0;
        repeat (3) tick();
        checkOutput("granted byte avail", rx_avail, 1);
        popCheck();

        // Asynchronous reset in the middle of a strobe.
        sendByte(8'h3C, 1'b1, 1'b0);
        ram1_data_in = 8'h99;
        data_ready   = 1'b1;
        guard = 0;
        while (rdn !== 1'b0 && guard < 20) begin
            tick();
            guard++;
        end
        checkOutput("strobe before reset", rdn, 0);
        #2 rst = 1'b0;
        #1;
        checkOutput("mid reset rdn", rdn, 1);
        checkOutput("mid reset bus_req", bus_req, 0);
        checkOutput("mid reset count", count, 0);
        checkOutput("mid reset avail", rx_avail, 0);
        sb.delete();
        data_ready = 1'b0;
        #2 rst = 1'b1;
        repeat (3) tick();
        checkOutput("post reset rdn", rdn, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
